// File: rtl/la_stream_bridge.sv
// la_stream_bridge: bridges a toggle-strobed logic-analyzer word stream into a
// first-word-fall-through FIFO feeding a decoder, and captures the decoder's
// result words back onto the analyzer side with a counter and a toggle flag.
module la_stream_bridge #(
  parameter int DATA_W = 16,                 // 8 or 16
  parameter int DEPTH  = 8,                  // power of two, 2..64
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 3,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [DATA_W-1:0] la_in_data,
  input  logic              la_in_toggle,
  input  logic [1:0]        la_mode,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  input  logic [OUT_W-1:0]  res_data,
  input  logic              res_valid,
  output logic [OUT_W-1:0]  la_out_data,
  output logic [CNT_W-1:0]  la_out_count,
  output logic [3:0]        la_out_status,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] LP_DEPTH = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_SWAP  = 2'b01,
    MODE_FLUSH = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  // storage and state
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_tog_q;
  logic              r_ovf;
  logic [DATA_W-1:0] r_last;
  logic [OUT_W-1:0]  r_out_data;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_res_tog;

  // decoded controls
  mode_e             w_mode;
  logic              w_flush;
  logic              w_hold;
  logic              w_empty;
  logic              w_full;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_push_drop;
  logic [DATA_W-1:0] w_swapped;
  logic [DATA_W-1:0] w_wdata;

  assign w_mode  = mode_e'(la_mode);
  assign w_flush = (w_mode == MODE_FLUSH);
  assign w_hold  = (w_mode == MODE_HOLD);
  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == LP_DEPTH);

  // Every level change of the strobe is one push request.
  assign w_push_req = la_in_toggle ^ r_tog_q;

  // Byte swap only has meaning for two-byte words; 8-bit words pass through.
  if (DATA_W == 16) begin : g_swap16
    assign w_swapped = {la_in_data[7:0], la_in_data[DATA_W-1:8]};
  end else begin : g_swap8
    assign w_swapped = la_in_data;
  end

  assign w_wdata = (w_mode == MODE_SWAP) ? w_swapped : la_in_data;

  // Head is offered whenever data exists, except while flushing.
  assign dec_valid = !w_empty && !w_flush;
  // Hold freezes the read side but still lets the write side fill.
  assign w_pop     = dec_valid && dec_ready && !w_hold;

  // A full FIFO still takes a push when a pop frees a slot at the same edge.
  assign w_push_ok   = w_push_req && !w_flush && (!w_full || w_pop);
  assign w_push_drop = w_push_req && !w_flush && !w_push_ok;

  // FWFT head; when empty, keep presenting the last head seen.
  assign dec_data = w_empty ? r_last : r_mem[r_rptr];

  assign la_out_data   = r_out_data;
  assign la_out_count  = r_out_cnt;
  assign la_out_status = {r_res_tog, r_ovf, w_full, w_empty};
  assign occupancy     = r_occ;

  // Strobe edge detector; also tracks the strobe during reset so that
  // leaving reset never creates a phantom push.
  always_ff @(posedge wb_clk_i) begin
    r_tog_q <= la_in_toggle;
  end

  // FIFO word storage; contents need no reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_ni && w_push_ok) r_mem[r_wptr] <= w_wdata;
  end

  // Pointers, occupancy and the overflow sticky bit.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_push_drop) r_ovf <= 1'b1;
    end
  end

  // Remember the head currently shown so it can be held once the FIFO drains.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) r_last <= '0;
    else            r_last <= dec_data;
  end

  // Result capture runs regardless of mode, flush included.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_out_data <= '0;
      r_out_cnt  <= '0;
      r_res_tog  <= 1'b0;
    end else if (res_valid) begin
      r_out_data <= res_data;
      r_out_cnt  <= r_out_cnt + 1'b1;
      r_res_tog  <= ~r_res_tog;
    end
  end

endmodule

// File: tb/tb_la_stream_bridge.sv
// tb_la_stream_bridge: queue-based reference model updated at each rising
// edge, one compare process at the falling edge, directed scenarios with
// literal expectations, then randomized traffic.
module tb_la_stream_bridge;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 3;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_tog;
  logic [1:0]        mode;
  logic [DATA_W-1:0] dec_data;
  logic              dec_valid;
  logic              dec_ready;
  logic [OUT_W-1:0]  res_data;
  logic              res_valid;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_cnt;
  logic [3:0]        status;
  logic [OCC_W-1:0]  occ;

  int total = 0;
  int bad   = 0;

  la_stream_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .la_in_data(in_data), .la_in_toggle(in_tog),
    .la_mode(mode), .dec_data(dec_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .res_data(res_data), .res_valid(res_valid), .la_out_data(out_data),
    .la_out_count(out_cnt), .la_out_status(status), .occupancy(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_last;
  logic              m_tog, m_ovf, m_rtog;
  logic [OUT_W-1:0]  m_out;
  int                m_cnt;
  bit                m_on = 0;

  always @(posedge clk) begin
    bit push, pop, flush, hold;
    logic [DATA_W-1:0] w;
    if (!rst_n) begin
      m_q.delete(); m_last = '0; m_ovf = 0; m_rtog = 0; m_out = '0; m_cnt = 0;
      m_tog = in_tog;
    end else begin
      push  = (in_tog != m_tog);
      m_tog = in_tog;
      flush = (mode == 2'b10);
      hold  = (mode == 2'b11);
      pop   = (m_q.size() != 0) && !flush && dec_ready && !hold;
      if (res_valid) begin
        m_out = res_data; m_cnt = (m_cnt + 1) % (1 << CNT_W); m_rtog = ~m_rtog;
      end
      if (m_q.size() != 0) m_last = m_q[0];
      if (flush) begin
        m_q.delete(); m_ovf = 0;
      end else begin
        w = (mode == 2'b01) ? {in_data[7:0], in_data[15:8]} : in_data;
        if (push && !(m_q.size() < DEPTH || pop)) m_ovf = 1;
        if (pop) void'(m_q.pop_front());
        if (push && (m_q.size() < DEPTH)) m_q.push_back(w);
      end
    end
    m_on = 1;
  end

  // single compare process, mid-cycle
  always @(negedge clk) begin
    if (m_on) begin
      chk("dec_valid", 32'(dec_valid), 32'((m_q.size() != 0) && (mode != 2'b10)));
      chk("dec_data", 32'(dec_data), 32'((m_q.size() != 0) ? m_q[0] : m_last));
      chk("occupancy", 32'(occ), 32'(m_q.size()));
      chk("status", 32'(status),
          32'({m_rtog, m_ovf, m_q.size() == DEPTH, m_q.size() == 0}));
      chk("out_data", 32'(out_data), 32'(m_out));
      chk("out_count", 32'(out_cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    in_data = d; in_tog = ~in_tog; cyc(1);
  endtask

  initial begin
    rst_n = 0; in_data = '0; in_tog = 0; mode = 2'b00; dec_ready = 0;
    res_data = '0; res_valid = 0;
    cyc(2);
    rst_n = 1;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_status", 32'(status), 32'h1);
    chk("rst_occ", 32'(occ), 32'd0);

    // single pass-through push
    push(16'hA55A);
    chk("p41_valid", 32'(dec_valid), 32'd1);
    chk("p41_data", 32'(dec_data), 32'hA55A);
    chk("p41_occ", 32'(occ), 32'd1);
    dec_ready = 1; cyc(1); dec_ready = 0;

    // byte swap
    mode = 2'b01; push(16'h1234);
    chk("p42_swap", 32'(dec_data), 32'h3412);
    mode = 2'b00; dec_ready = 1; cyc(1); dec_ready = 0;

    // overflow: 9 pushes into 8 slots
    for (int i = 0; i < 9; i++) push(DATA_W'(i));
    chk("p43_occ", 32'(occ), 32'd8);
    chk("p43_status", 32'(status), 32'h6);
    dec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("p43_drain", 32'(dec_data), 32'(i));
      cyc(1);
    end
    dec_ready = 0;
    chk("p43_empty", 32'(occ), 32'd0);
    chk("p43_sticky", 32'(status[2]), 32'd1);

    // full FIFO with simultaneous pop and push
    mode = 2'b10; cyc(1); mode = 2'b00;
    for (int i = 0; i < 8; i++) push(DATA_W'(16'h100 + i));
    dec_ready = 1; push(16'h0BEE); dec_ready = 0;
    chk("p44_occ", 32'(occ), 32'd8);
    chk("p44_ovf", 32'(status[2]), 32'd0);
    chk("p44_head", 32'(dec_data), 32'h101);

    // overflow, then a one-cycle flush
    push(16'hDEAD);
    chk("p46_ovf_set", 32'(status[2]), 32'd1);
    mode = 2'b10; cyc(1); mode = 2'b00;
    chk("p46_occ", 32'(occ), 32'd0);
    chk("p46_valid", 32'(dec_valid), 32'd0);
    chk("p46_ovf", 32'(status[2]), 32'd0);
    for (int i = 0; i < 5; i++) push(DATA_W'(i + 40));
    mode = 2'b10; cyc(1); mode = 2'b00;
    chk("p46_occ5", 32'(occ), 32'd0);

    // hold: pushes accepted, pops blocked
    mode = 2'b11; dec_ready = 1; push(16'h7777); push(16'h8888);
    chk("hold_occ", 32'(occ), 32'd2);
    mode = 2'b00; cyc(2); dec_ready = 0;

    // nine results
    for (int i = 0; i < 9; i++) begin
      res_data = OUT_W'(i); res_valid = 1; cyc(1); res_valid = 0; cyc(1);
    end
    chk("p45_data", 32'(out_data), 32'h08);
    chk("p45_cnt", 32'(out_cnt), 32'd1);
    chk("p45_tog", 32'(status[3]), 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      mode = (r < 40) ? 2'b00 : (r < 75) ? 2'b01 : (r < 82) ? 2'b10 : 2'b11;
      in_data   = DATA_W'($urandom);
      if ($urandom_range(0, 1) == 1) in_tog = ~in_tog;
      dec_ready = ($urandom_range(0, 2) == 0);
      res_valid = ($urandom_range(0, 3) == 0);
      res_data  = OUT_W'($urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
      cyc(1);
      rst_n = 1;
    end

    // reset mid-stream with the strobe moving
    mode = 2'b00; dec_ready = 0; res_valid = 0;
    for (int i = 0; i < 4; i++) push(DATA_W'(i + 200));
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin in_tog = ~in_tog; res_valid = 1; cyc(1); end
    res_valid = 0; rst_n = 1; cyc(1);
    chk("p47_valid", 32'(dec_valid), 32'd0);
    chk("p47_status", 32'(status), 32'h1);
    chk("p47_occ", 32'(occ), 32'd0);
    chk("p47_cnt", 32'(out_cnt), 32'd0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/la_stream_bridge.md
LA_STREAM_BRIDGE -- requirements
Module: la_stream_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ingress word width; legal values 8 or 16 only.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO depth in words; power of two, 2..64.
REQ-003 SHALL have parameter OUT_W, default 8, result word width.
REQ-004 SHALL have parameter CNT_W, default 3, result counter width.
REQ-005 SHALL have parameter OCC_W, default $clog2(DEPTH+1), occupancy width.
REQ-006 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port wb_rst_ni, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port la_in_data, input, DATA_W, bitstream word from the logic analyzer.
REQ-009 SHALL have port la_in_toggle, input, 1, push strobe; each level change requests one push.
REQ-010 SHALL have port la_mode, input, 2, mode: 00 pass, 01 byte-swap, 10 flush, 11 hold.
REQ-011 SHALL have port dec_data, output, DATA_W, FIFO head word to the decoder.
REQ-012 SHALL have port dec_valid, output, 1, head word valid.
REQ-013 SHALL have port dec_ready, input, 1, decoder accepts the head word.
REQ-014 SHALL have port res_data, input, OUT_W, decoder result word.
REQ-015 SHALL have port res_valid, input, 1, single-cycle result strobe.
REQ-016 SHALL have port la_out_data, output, OUT_W, last captured result.
REQ-017 SHALL have port la_out_count, output, CNT_W, captured-result counter.
REQ-018 SHALL have port la_out_status, output, 4, status: [0] empty, [1] full, [2] overflow sticky, [3] result-toggle.
REQ-019 SHALL have port occupancy, output, OCC_W, current FIFO word count.

Function
REQ-020 Push request SHALL be asserted when la_in_toggle differs from tog_q; tog_q SHALL be la_in_toggle registered every cycle.
REQ-021 On a push, the word written SHALL be la_in_data in modes 00 and 11.
REQ-022 On a push in mode 01, the two bytes of la_in_data SHALL be swapped; when DATA_W=8 the word SHALL be unchanged.
REQ-023 A pop SHALL occur when dec_valid && dec_ready && la_mode!=11 && la_mode!=10.
REQ-024 A push SHALL be accepted when occupancy<DEPTH, or when occupancy==DEPTH and a pop occurs in the same cycle.
REQ-025 Otherwise the push SHALL be dropped and status[2] SHALL be set, remaining set until reset or flush.
REQ-026 dec_valid SHALL equal (occupancy!=0) && la_mode!=10.
REQ-027 dec_data SHALL be the head word (FWFT); when empty, dec_data SHALL hold its last value.
REQ-028 A word pushed into an empty FIFO at edge N SHALL appear on dec_data/dec_valid after edge N, i.e. one-cycle latency from push request to dec_valid.
REQ-029 In mode 11 (hold), pushes SHALL still be accepted and pops SHALL be blocked.
REQ-030 Mode 10 (flush) SHALL, at each edge while selected, set occupancy to 0, reset both pointers, and clear status[2].
REQ-031 In mode 10, pushes SHALL be ignored and SHALL NOT set overflow.
REQ-032 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH with no gap.
REQ-034 On res_valid, la_out_data SHALL be loaded with res_data, la_out_count SHALL increment modulo 2^CNT_W (7->0 at default), and status[3] SHALL invert, all at the same edge.
REQ-035 Result capture SHALL be independent of la_mode, including flush.
REQ-036 status[0] SHALL equal (occupancy==0) and status[1] SHALL equal (occupancy==DEPTH), registered-consistent with occupancy.

Reset
REQ-037 While wb_rst_ni==0 at a rising edge, the following SHALL clear to 0: occupancy, pointers, dec_data, la_out_data, la_out_count, status[3:2].
REQ-038 While in reset, tog_q SHALL load la_in_toggle so that no spurious push occurs on release.
REQ-039 Reset SHALL override flush, push, pop and res_valid in the same cycle; FIFO contents are don't-care after reset.
REQ-040 After reset, dec_valid SHALL be 0 and la_out_status SHALL be 4'b0001.

Verification
REQ-041 Reset, then toggle with la_in_data=16'hA55A in mode 00 -> dec_valid=1 next cycle, dec_data=16'hA55A, occupancy=1.
REQ-042 Mode 01, push 16'h1234 -> dec_data=16'h3412.
REQ-043 With dec_ready=0, push 9 words 0..8 (DEPTH=8) -> occupancy=8, status=4'b0110, word 8 dropped; then drain -> data 0..7 in order.
REQ-044 Full FIFO with dec_ready=1 and push in the same cycle -> push accepted, occupancy stays 8, status[2] unchanged.
REQ-045 Issue 9 res_valid pulses with res_data=i -> la_out_data=8'h08, la_out_count=1, status[3]=1.
REQ-046 Fill 5 words, then mode 10 for one cycle, then mode 00 -> occupancy=0, dec_valid=0, status[2]=0.
REQ-047 Assert wb_rst_ni=0 mid-stream with toggle changing -> after release, no push occurs and outputs match REQ-040.
